// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared sizes, state encoding and key-order field helpers
package rr_mux_arbiter_pkg;

    localparam int NR_REQ   = 4;
    localparam int DATA_LEN = 2;
    localparam int SEL_LEN  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Key order: requester 0 occupies the most significant field of data_in.
    function automatic logic [DATA_LEN-1:0] field_of(
        input logic [NR_REQ*DATA_LEN-1:0] d,
        input logic [SEL_LEN-1:0]         k
    );
        logic [DATA_LEN-1:0] f;
        f = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (k == SEL_LEN'(i)) begin
                f = d[DATA_LEN*(NR_REQ-i)-1 -: DATA_LEN];
            end
        end
        return f;
    endfunction

    function automatic logic [NR_REQ-1:0] onehot(input logic [SEL_LEN-1:0] k);
        logic [NR_REQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/consumer bus of the round-robin arbiter
interface rr_mux_arbiter_if;
    import rr_mux_arbiter_pkg::*;

    logic [NR_REQ-1:0]          req;
    logic [NR_REQ*DATA_LEN-1:0] data_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_LEN-1:0]        out_data;
    logic [SEL_LEN-1:0]         out_sel;
    logic [NR_REQ-1:0]          ack;

    modport master (
        input  req, data_in, out_ready,
        output out_valid, out_data, out_sel, ack
    );

    modport slave (
        output req, data_in, out_ready,
        input  out_valid, out_data, out_sel, ack
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder searching from ptr upward, modulo NR_REQ
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NR_REQ-1:0]  req,
    input  logic [NR_REQ-1:0]  mask,
    input  logic [SEL_LEN-1:0] ptr,
    output logic               any,
    output logic [SEL_LEN-1:0] winner
);

    logic [NR_REQ-1:0]  eligible;
    logic [SEL_LEN-1:0] idx;

    assign eligible = req & ~mask;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int off = 0; off < NR_REQ; off++) begin
            idx = ptr + SEL_LEN'(off);
            if (!any && eligible[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter capturing the granted field under valid/ready
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rr_mux_arbiter_if.master  bus
);

    state_t              state_q, state_d;
    logic [SEL_LEN-1:0]  ptr_q, ptr_d;
    logic [SEL_LEN-1:0]  sel_q, sel_d;
    logic [DATA_LEN-1:0] data_q, data_d;

    logic                handshake;
    logic [SEL_LEN-1:0]  pick_ptr;
    logic [NR_REQ-1:0]   pick_mask;
    logic                pick_any;
    logic [SEL_LEN-1:0]  pick_winner;

    // On a handshake the just-served requester is masked and search restarts after it.
    assign handshake = (state_q == HOLD) && bus.out_ready;
    assign pick_ptr  = handshake ? sel_q + SEL_LEN'(1) : ptr_q;
    assign pick_mask = handshake ? onehot(sel_q) : '0;

    rr_pick u_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_winner;
                    data_d  = field_of(bus.data_in, pick_winner);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    ptr_d = pick_ptr;
                    if (pick_any) begin
                        sel_d  = pick_winner;
                        data_d = field_of(bus.data_in, pick_winner);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sel   = sel_q;
    assign bus.out_data  = data_q;
    assign bus.ack       = handshake ? onehot(sel_q) : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rr_mux_arbiter_if bus();

    rr_mux_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.data_in   = 8'b11_10_01_00;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.out_sel); end
        checks++;
        if (bus.out_data !== 2'b00) begin errors++; $display("FAIL reset_data got=%b exp=00", bus.out_data); end
        checks++;
        if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== 2'b11) begin
            errors++;
            $display("FAIL first_grant got=v%0b s%0d d%b exp=v1 s0 d11", bus.out_valid, bus.out_sel, bus.out_data);
        end
        bus.out_ready = 1'b1;
        bus.req       = 4'b0000;
        #1;
        checks++;
        if (bus.ack !== 4'b0001) begin errors++; $display("FAIL first_ack got=%b exp=0001", bus.ack); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL first_idle got=%0b exp=0", bus.out_valid); end
    endtask

    // ptr is 1 on entry
    task automatic test_single();
        bus.data_in   = 8'b00_01_10_11;
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 2'b10) begin
            errors++;
            $display("FAIL single_grant got=v%0b s%0d d%b exp=v1 s2 d10", bus.out_valid, bus.out_sel, bus.out_data);
        end
        checks++;
        if (bus.ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", bus.ack); end
        bus.req = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle got=v%0b a%b exp=v0 a0000", bus.out_valid, bus.ack);
        end
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_sel !== 2'd3) begin errors++; $display("FAIL single_ptr got=%0d exp=3", bus.out_sel); end
        bus.req       = 4'b0000;
        bus.out_ready = 1'b1;
        step();
    endtask

    // ptr is 0 on entry
    task automatic test_round_robin();
        logic [1:0] exp_sel[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_ack[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.data_in   = 8'b01_10_11_00;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel[i] || bus.ack !== exp_ack[i]) begin
                errors++;
                $display("FAIL rr_cycle%0d got=v%0b s%0d a%b exp=v1 s%0d a%b",
                         i, bus.out_valid, bus.out_sel, bus.ack, exp_sel[i], exp_ack[i]);
            end
            if (i == 4) bus.req = 4'b0000;
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_end got=%0b exp=0", bus.out_valid); end
    endtask

    // ptr is 1 on entry
    task automatic test_backpressure();
        logic [1:0] f1[3] = '{2'b01, 2'b11, 2'b00};
        bus.data_in   = 8'b00_10_00_00;
        bus.req       = 4'b0010;
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant got=v%0b s%0d d%b exp=v1 s1 d10", bus.out_valid, bus.out_sel, bus.out_data);
        end
        for (int i = 0; i < 3; i++) begin
            bus.data_in = {2'b00, f1[i], 4'b0000};
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 2'b10 || bus.ack !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%0b d%b a%b exp=v1 d10 a0000", i, bus.out_valid, bus.out_data, bus.ack);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.ack !== 4'b0010) begin errors++; $display("FAIL bp_ack got=%b exp=0010", bus.ack); end
        step();
        bus.req = 4'b0000;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL bp_single_pulse got=v%0b a%b exp=v0 a0000", bus.out_valid, bus.ack);
        end
    endtask

    // ptr is 2 on entry
    task automatic test_mask();
        bus.data_in   = 8'b00_00_00_01;
        bus.req       = 4'b1000;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3 || bus.ack !== 4'b1000 || bus.out_data !== 2'b01) begin
            errors++;
            $display("FAIL mask_grant got=v%0b s%0d a%b d%b exp=v1 s3 a1000 d01",
                     bus.out_valid, bus.out_sel, bus.ack, bus.out_data);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mask_gap got=%0b exp=0", bus.out_valid); end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3) begin
            errors++;
            $display("FAIL mask_regrant got=v%0b s%0d exp=v1 s3", bus.out_valid, bus.out_sel);
        end
        bus.req = 4'b0000;
        step();
    endtask

    // ptr is 0 on entry; move it to 2 before resetting in HOLD
    task automatic test_reset_mid();
        bus.data_in   = 8'b00_01_10_11;
        bus.req       = 4'b0110;
        bus.out_ready = 1'b1;
        step();
        bus.req = 4'b0100;
        step();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup got=v%0b s%0d exp=v1 s2", bus.out_valid, bus.out_sel);
        end
        rst = 1'b1;
        step();
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000 || bus.out_sel !== 2'd0 || bus.out_data !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got=v%0b a%b s%0d d%b exp=v0 a0000 s0 d00",
                     bus.out_valid, bus.ack, bus.out_sel, bus.out_data);
        end
        rst           = 1'b0;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 2'b00) begin
            errors++;
            $display("FAIL mid_ptr got=s%0d d%b exp=s0 d00", bus.out_sel, bus.out_data);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.req       = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
